// File: rtl/johnson_slot_arbiter.sv
// johnson_slot_arbiter
//
// Time-slot arbiter that shares one resource among 8 requesters in a fixed
// rotating order. The slot pointer is a self-correcting 4-bit Johnson ring
// with 8 valid states. A requester is granted only while the pointer sits on
// its slot. A grant lasts at most MAX_HOLD cycles, and then the ring moves on.
// This gives every requester a bounded worst-case wait.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rstn     in   1  asynchronous active-low reset
//   en       in   1  scan enable; 0 freezes the pointer and blocks new grants
//   req      in   8  request vector, req[k] belongs to slot k
//   gnt      out  8  registered one-hot grant, zero when idle
//   busy     out  1  high while a grant is active
//   timeout  out  1  one-cycle pulse when a grant is cut by the MAX_HOLD limit
//   slot     out  3  binary index of the current slot
//   phase    out  8  one-hot decode of the current slot (zero if ring illegal)
//   jstate   out  4  raw Johnson ring state
//   err      out  1  sticky: an illegal ring state was seen since reset

module johnson_slot_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] slot,
  output logic [7:0] phase,
  output logic [3:0] jstate,
  output logic       err
);

  typedef enum logic {
    ST_SCAN  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // hold_cnt counts from 0, so the last allowed grant cycle is MAX_HOLD-1.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] jstate_q, jstate_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       timeout_q, timeout_d;
  logic       err_q, err_d;

  logic       ring_legal;
  logic [2:0] slot_idx;
  logic [3:0] jstate_adv;
  logic       req_cur;

  // Decode the ring. Codes outside the 8-state Johnson sequence are illegal.
  always_comb begin
    ring_legal = 1'b1;
    slot_idx   = 3'd0;
    unique case (jstate_q)
      4'b0000: slot_idx = 3'd0;
      4'b1000: slot_idx = 3'd1;
      4'b1100: slot_idx = 3'd2;
      4'b1110: slot_idx = 3'd3;
      4'b1111: slot_idx = 3'd4;
      4'b0111: slot_idx = 3'd5;
      4'b0011: slot_idx = 3'd6;
      4'b0001: slot_idx = 3'd7;
      default: ring_legal = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_phase
      assign phase[gi] = ring_legal && (slot_idx == 3'(gi));
    end
  endgenerate

  // One Johnson step: shift right and feed the inverted LSB into the MSB.
  assign jstate_adv = {~jstate_q[0], jstate_q[3:1]};
  assign req_cur    = req[slot_idx];

  always_comb begin
    state_d    = state_q;
    jstate_d   = jstate_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    timeout_d  = 1'b0;
    err_d      = err_q;

    if (!ring_legal) begin
      // Recover to s0 unconditionally. Any grant is abandoned without a timeout.
      jstate_d   = 4'b0000;
      err_d      = 1'b1;
      gnt_d      = 8'h00;
      state_d    = ST_SCAN;
      hold_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        ST_SCAN: begin
          if (en) begin
            if (req_cur) begin
              gnt_d      = phase;
              state_d    = ST_GRANT;
              hold_cnt_d = 4'd0;
            end else begin
              jstate_d = jstate_adv;
            end
          end
        end
        ST_GRANT: begin
          // en is deliberately ignored here so an active grant always runs out.
          if (!req_cur || (hold_cnt_q == HOLD_LAST)) begin
            gnt_d      = 8'h00;
            state_d    = ST_SCAN;
            jstate_d   = jstate_adv;
            hold_cnt_d = 4'd0;
            // Still requesting at release means the limit ended the grant.
            timeout_d  = req_cur;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_SCAN;
      jstate_q   <= 4'b0000;
      hold_cnt_q <= 4'd0;
      gnt_q      <= 8'h00;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      jstate_q   <= jstate_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q == ST_GRANT);
  assign timeout = timeout_q;
  assign slot    = slot_idx;
  assign jstate  = jstate_q;
  assign err     = err_q;

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
// Bench for johnson_slot_arbiter: a slot-level model, checked every cycle, plus
// hand-computed expectations at the points called out in the test plan.
module tb_johnson_slot_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       en   = 1'b0;
  logic [7:0] req  = 8'h00;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;
  logic [2:0] slot;
  logic [7:0] phase;
  logic [3:0] jstate;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Ring code for each slot, as listed in the slot map.
  logic [3:0] jtab [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};

  // Illegal-state injection bookkeeping: the stimulus bumps inj_count, and the
  // model consumes it at the next edge.
  int         inj_count = 0;
  int         inj_seen  = 0;
  logic [3:0] inj_code  = 4'b0000;

  // Model state: the current slot number, whether a grant is active, and how
  // many cycles the grant has lasted so far.
  int m_slot = 0;
  bit m_on   = 1'b0;
  int m_cnt  = 0;
  bit m_err  = 1'b0;
  bit m_to   = 1'b0;

  always #5 clk = ~clk;

  johnson_slot_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout),
    .slot   (slot),
    .phase  (phase),
    .jstate (jstate),
    .err    (err)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_slot   <= 0;
      m_on     <= 1'b0;
      m_cnt    <= 0;
      m_err    <= 1'b0;
      m_to     <= 1'b0;
      inj_seen <= inj_count;
    end else begin
      m_to <= 1'b0;
      if (inj_count != inj_seen) begin
        m_slot   <= 0;
        m_on     <= 1'b0;
        m_cnt    <= 0;
        m_err    <= 1'b1;
        inj_seen <= inj_count;
      end else if (!m_on) begin
        if (en) begin
          if (req[m_slot]) begin
            m_on  <= 1'b1;
            m_cnt <= 1;
          end else begin
            m_slot <= (m_slot + 1) % 8;
          end
        end
      end else if (!req[m_slot] || m_cnt == MAX_HOLD) begin
        m_on   <= 1'b0;
        m_cnt  <= 0;
        m_to   <= req[m_slot];
        m_slot <= (m_slot + 1) % 8;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit         ill;
    logic [7:0] e_gnt;
    logic [7:0] e_phase;
    logic [3:0] e_j;
    logic [2:0] e_slot;
    ill     = (inj_count != inj_seen);
    e_gnt   = m_on ? 8'(1 << m_slot) : 8'h00;
    e_phase = ill ? 8'h00 : 8'(1 << m_slot);
    e_j     = ill ? inj_code : jtab[m_slot];
    e_slot  = ill ? 3'd0 : 3'(m_slot);
    cyc++;
    $display("cyc %0d: rstn=%b en=%b req=%h | gnt=%h busy=%b to=%b slot=%0d phase=%h j=%b err=%b",
             cyc, rstn, en, req, gnt, busy, timeout, slot, phase, jstate, err);
    chk("model_gnt", gnt, e_gnt);
    chk("model_busy", {7'd0, busy}, {7'd0, m_on});
    chk("model_timeout", {7'd0, timeout}, {7'd0, m_to});
    chk("model_slot", {5'd0, slot}, {5'd0, e_slot});
    chk("model_phase", phase, e_phase);
    chk("model_jstate", {4'd0, jstate}, {4'd0, e_j});
    chk("model_err", {7'd0, err}, {7'd0, m_err});
  endtask

  // One clock edge. The model is compared mid-cycle, and control returns 3ns
  // after the edge so that the stimulus and the literal checks land away from
  // the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #3;
    end
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset with arbitrary inputs.
    rstn = 1'b0; en = 1'b1; req = 8'hff;
    tick(3);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_phase", phase, 8'h01);
    chk("rst_jstate", {4'd0, jstate}, 8'h00);
    chk("rst_busy_to_err", {5'd0, busy, timeout, err}, 8'h00);

    // Free run.
    en = 1'b1; req = 8'h00; rstn = 1'b1;
    tick(1);
    chk("free_slot1", {5'd0, slot}, 8'd1);
    chk("free_phase1", phase, 8'h02);
    chk("free_j1", {4'd0, jstate}, 8'b0000_1000);
    tick(3);
    chk("free_j4", {4'd0, jstate}, 8'b0000_1111);
    chk("free_phase4", phase, 8'h10);
    tick(4);
    chk("free_wrap_slot", {5'd0, slot}, 8'd0);
    chk("free_wrap_gnt", gnt, 8'h00);

    // Hold limit.
    reset_dut();
    en = 1'b1; req = 8'h08;
    tick(3);
    chk("hold_e3_slot", {5'd0, slot}, 8'd3);
    chk("hold_e3_gnt", gnt, 8'h00);
    tick(1);
    chk("hold_e4_gnt", gnt, 8'h08);
    chk("hold_e4_busy", {7'd0, busy}, 8'd1);
    tick(3);
    chk("hold_e7_gnt", gnt, 8'h08);
    tick(1);
    chk("hold_e8_gnt", gnt, 8'h00);
    chk("hold_e8_timeout", {7'd0, timeout}, 8'd1);
    chk("hold_e8_slot", {5'd0, slot}, 8'd4);
    tick(1);
    chk("hold_e9_timeout", {7'd0, timeout}, 8'd0);
    tick(6);
    chk("hold_e15_gnt", gnt, 8'h00);
    tick(1);
    chk("hold_e16_gnt", gnt, 8'h08);

    // Early release.
    reset_dut();
    en = 1'b1; req = 8'h00;
    tick(5);
    chk("early_slot5", {5'd0, slot}, 8'd5);
    req = 8'h20;
    tick(2);
    chk("early_gnt2", gnt, 8'h20);
    req = 8'h00;
    tick(1);
    chk("early_rel_gnt", gnt, 8'h00);
    chk("early_rel_timeout", {7'd0, timeout}, 8'd0);
    chk("early_rel_slot", {5'd0, slot}, 8'd6);

    // Enable gating while scanning.
    reset_dut();
    en = 1'b1; req = 8'h00;
    tick(2);
    en = 1'b0; req = 8'hff;
    tick(5);
    chk("en_frozen_slot", {5'd0, slot}, 8'd2);
    chk("en_frozen_gnt", gnt, 8'h00);

    // Enable dropped during a grant of slot 1.
    reset_dut();
    en = 1'b1; req = 8'h02;
    tick(2);
    chk("eng_gnt", gnt, 8'h02);
    en = 1'b0;
    tick(3);
    chk("eng_gnt_held", gnt, 8'h02);
    tick(1);
    chk("eng_rel_gnt", gnt, 8'h00);
    chk("eng_rel_slot", {5'd0, slot}, 8'd2);
    tick(3);
    chk("eng_frozen_slot", {5'd0, slot}, 8'd2);

    // Illegal ring state during a grant.
    reset_dut();
    en = 1'b1; req = 8'h01;
    tick(2);
    inj_code = 4'b0101;
    force dut.jstate_q = 4'b0101;
    #1;
    release dut.jstate_q;
    inj_count++;
    chk("ill_jstate", {4'd0, jstate}, 8'b0000_0101);
    chk("ill_phase", phase, 8'h00);
    chk("ill_slot", {5'd0, slot}, 8'd0);
    tick(1);
    chk("ill_rec_jstate", {4'd0, jstate}, 8'h00);
    chk("ill_rec_gnt", gnt, 8'h00);
    chk("ill_rec_err", {7'd0, err}, 8'd1);
    chk("ill_rec_timeout", {7'd0, timeout}, 8'd0);
    tick(2);
    chk("ill_err_sticky", {7'd0, err}, 8'd1);
    chk("ill_regrant", gnt, 8'h01);

    // Asynchronous reset mid-grant, with no clock edge involved.
    rstn = 1'b0;
    #1;
    chk("async_gnt", gnt, 8'h00);
    chk("async_busy", {7'd0, busy}, 8'd0);
    chk("async_err", {7'd0, err}, 8'd0);
    chk("async_jstate", {4'd0, jstate}, 8'h00);
    tick(1);
    rstn = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
